// File: rtl/logic_gate_pkg.sv
// Shared definitions for the registered bitwise gate unit: gate enumeration,
// gate count and the a=0/b=0 reset row.
package logic_gate_pkg;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NOT  = 3'd2,
    GATE_NAND = 3'd3,
    GATE_NOR  = 3'd4,
    GATE_XOR  = 3'd5,
    GATE_XNOR = 3'd6
  } gate_e;

  localparam int NUM_GATES = 7;

  // Value each gate produces for a=0, b=0; results reset to this row.
  function automatic logic reset_bit(input int g);
    return !(g == int'(GATE_AND) || g == int'(GATE_OR) || g == int'(GATE_XOR));
  endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Purely combinational gate core: one set of gate primitives per operand bit.
module logic_gate_core #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] and_o,
  output logic [WIDTH-1:0] or_o,
  output logic [WIDTH-1:0] not_o,
  output logic [WIDTH-1:0] nand_o,
  output logic [WIDTH-1:0] nor_o,
  output logic [WIDTH-1:0] xor_o,
  output logic [WIDTH-1:0] xnor_o
);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      and  u_and  (and_o[i],  a_i[i], b_i[i]);
      or   u_or   (or_o[i],   a_i[i], b_i[i]);
      not  u_not  (not_o[i],  a_i[i]);
      nand u_nand (nand_o[i], a_i[i], b_i[i]);
      nor  u_nor  (nor_o[i],  a_i[i], b_i[i]);
      xor  u_xor  (xor_o[i],  a_i[i], b_i[i]);
      xnor u_xnor (xnor_o[i], a_i[i], b_i[i]);
    end
  endgenerate

endmodule

// File: rtl/logic_gate.sv
// Registered bitwise gate unit: combinational core plus one output register
// stage with valid tracking. Latency is one cycle, one operand pair per cycle.
module logic_gate
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_gate,
  output logic [WIDTH-1:0] or_gate,
  output logic [WIDTH-1:0] not_gate,
  output logic [WIDTH-1:0] nand_gate,
  output logic [WIDTH-1:0] nor_gate,
  output logic [WIDTH-1:0] xor_gate,
  output logic [WIDTH-1:0] xnor_gate
);

  logic [NUM_GATES-1:0][WIDTH-1:0] res_d;
  logic [NUM_GATES-1:0][WIDTH-1:0] res_q;
  logic                            valid_q;

  logic_gate_core #(.WIDTH(WIDTH)) u_core (
    .a_i   (a),
    .b_i   (b),
    .and_o (res_d[GATE_AND]),
    .or_o  (res_d[GATE_OR]),
    .not_o (res_d[GATE_NOT]),
    .nand_o(res_d[GATE_NAND]),
    .nor_o (res_d[GATE_NOR]),
    .xor_o (res_d[GATE_XOR]),
    .xnor_o(res_d[GATE_XNOR])
  );

  // in_valid is a pure qualifier (no back-pressure): a high sample loads all
  // results and raises out_valid for exactly the following cycle; a low sample
  // holds the results, so operands are never looked at while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < NUM_GATES; g++) begin
        res_q[g] <= {WIDTH{reset_bit(g)}};
      end
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q <= res_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign and_gate  = res_q[GATE_AND];
  assign or_gate   = res_q[GATE_OR];
  assign not_gate  = res_q[GATE_NOT];
  assign nand_gate = res_q[GATE_NAND];
  assign nor_gate  = res_q[GATE_NOR];
  assign xor_gate  = res_q[GATE_XOR];
  assign xnor_gate = res_q[GATE_XNOR];

endmodule

// File: tb/tb_logic_gate.sv
// Bench for logic_gate: WIDTH=1 and WIDTH=8 instances share one stimulus
// stream and are checked against a truth-table reference model.
module tb_logic_gate;
  import logic_gate_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;

  logic       ov1, ov8;
  logic [0:0] and1, or1, not1, nand1, nor1, xor1, xnor1;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;

  logic_gate #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a[0:0]), .b(b[0:0]),
    .out_valid(ov1), .and_gate(and1), .or_gate(or1), .not_gate(not1),
    .nand_gate(nand1), .nor_gate(nor1), .xor_gate(xor1), .xnor_gate(xnor1)
  );

  logic_gate #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(ov8), .and_gate(and8), .or_gate(or8), .not_gate(not8),
    .nand_gate(nand8), .nor_gate(nor8), .xor_gate(xor8), .xnor_gate(xnor8)
  );

  logic [6:0][7:0] got8;
  logic [6:0]      got1;
  assign got8[GATE_AND]  = and8;
  assign got8[GATE_OR]   = or8;
  assign got8[GATE_NOT]  = not8;
  assign got8[GATE_NAND] = nand8;
  assign got8[GATE_NOR]  = nor8;
  assign got8[GATE_XOR]  = xor8;
  assign got8[GATE_XNOR] = xnor8;
  assign got1[GATE_AND]  = and1[0];
  assign got1[GATE_OR]   = or1[0];
  assign got1[GATE_NOT]  = not1[0];
  assign got1[GATE_NAND] = nand1[0];
  assign got1[GATE_NOR]  = nor1[0];
  assign got1[GATE_XOR]  = xor1[0];
  assign got1[GATE_XNOR] = xnor1[0];

  // ---------------- reference model ----------------
  logic [7:0] exp8 [NUM_GATES];
  logic       exp_valid;
  int         n_checks;
  int         n_fail;

  // Truth table indexed by {a,b}: bit 3 is the a=1,b=1 row.
  function automatic logic [7:0] ref_gate(input int g, input logic [7:0] av, input logic [7:0] bv);
    logic [3:0] tt;
    logic [7:0] r;
    case (g)
      0:       tt = 4'b1000;
      1:       tt = 4'b1110;
      2:       tt = 4'b0011;
      3:       tt = 4'b0111;
      4:       tt = 4'b0001;
      5:       tt = 4'b0110;
      default: tt = 4'b1001;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{av[i], bv[i]}];
    return r;
  endfunction

  task automatic set_reset_exp();
    for (int g = 0; g < NUM_GATES; g++) exp8[g] = ref_gate(g, 8'h00, 8'h00);
    exp_valid = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    gate_e ge;
    for (int g = 0; g < NUM_GATES; g++) begin
      ge = gate_e'(g);
      check($sformatf("w8_%s", ge.name()), got8[g], exp8[g]);
      check($sformatf("w1_%s", ge.name()), {7'b0, got1[g]}, {7'b0, exp8[g][0]});
    end
    check("w8_valid", {7'b0, ov8}, {7'b0, exp_valid});
    check("w1_valid", {7'b0, ov1}, {7'b0, exp_valid});
    check("inv_nand", nand8, ~and8);
    check("inv_nor",  nor8,  ~or8);
    check("inv_xnor", xnor8, ~xor8);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    if (!rst_n) begin
      set_reset_exp();
    end else begin
      exp_valid = v;
      if (v) for (int g = 0; g < NUM_GATES; g++) exp8[g] = ref_gate(g, av, bv);
    end
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] rows [4];
    logic [7:0] wide [NUM_GATES];
    logic [1:0] ab;
    n_checks = 0;
    n_fail   = 0;
    rows = '{7'b0011101, 7'b0111010, 7'b0101010, 7'b1100001};
    wide = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3};
    rst_n    = 1'b1;
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    set_reset_exp();
    #2 rst_n = 1'b0;
    #1 check_all();

    // Reset held with active-looking inputs
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 8'hFF);
    @(negedge clk) rst_n = 1'b1;

    // Exhaustive 1-bit truth table, also against literal rows
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      cycle(1'b1, {7'b0, ab[1]}, {7'b0, ab[0]});
      for (int g = 0; g < NUM_GATES; g++)
        check($sformatf("tt%0d_g%0d", i, g), {7'b0, got1[g]}, {7'b0, rows[i][6-g]});
      check("tt_valid", {7'b0, ov1}, 8'h01);
    end

    // Hold: capture a=1,b=0 then idle with different operands
    cycle(1'b1, 8'h01, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 8'h01);
      check("hold_and1", {7'b0, and1[0]}, 8'h00);
      check("hold_not1", {7'b0, not1[0]}, 8'h00);
      check("hold_xor1", {7'b0, xor1[0]}, 8'h01);
      check("hold_valid", {7'b0, ov8}, 8'h00);
    end

    // Wide operands against literal results
    cycle(1'b1, 8'hF0, 8'hCC);
    for (int g = 0; g < NUM_GATES; g++) check($sformatf("wide_g%0d", g), got8[g], wide[g]);

    // Async reset between edges after capturing 11
    cycle(1'b1, 8'hFF, 8'hFF);
    #3 rst_n = 1'b0;
    #1;
    set_reset_exp();
    check_all();
    cycle(1'b1, 8'hFF, 8'hFF);
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b1, 8'h5A, 8'h3C);
    check("post_rst_xor", xor8, 8'h66);

    // Random traffic
    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
